// File: rtl/osd_pkg.sv
// -----------------------------------------------------------------------------
// osd_pkg
// Shared definitions for the OSD rectangle writer: bitmap geometry, the
// controller state encoding, the latched command record and a bounds check.
// No ports (package).
// -----------------------------------------------------------------------------
package osd_pkg;

  localparam int OSD_WIDTH   = 520;
  localparam int OSD_HEIGHT  = 400;
  localparam int OSD_ADDR_W  = 19;
  localparam int OSD_COORD_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } osd_state_e;

  typedef struct packed {
    logic [OSD_COORD_W-1:0] x0;
    logic [OSD_COORD_W-1:0] y0;
    logic [OSD_COORD_W-1:0] x1;
    logic [OSD_COORD_W-1:0] y1;
    logic                   color;
  } osd_cmd_t;

  // A rectangle is legal when its corners are ordered and it lies fully
  // inside the bitmap.
  function automatic logic cmd_in_bounds(input osd_cmd_t c, input int w, input int h);
    return (c.x0 <= c.x1) && (c.y0 <= c.y1) &&
           (int'(c.x1) < w) && (int'(c.y1) < h);
  endfunction

endpackage

// File: rtl/osd_addr_gen.sv
// -----------------------------------------------------------------------------
// osd_addr_gen
// Raster walker for a rectangle fill. Holds the column/row counters and the
// linear address plus the address of the current row start. Addresses are
// produced incrementally; the only multiply (row base of the first row) is
// done by the caller and presented on base_i together with load_i.
//
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   load_i  start a new rectangle at (x0_i, y0_i), address base_i
//   step_i  advance one pixel in raster order
//   base_i  y0*WIDTH + x0
//   x0_i    left column (held stable for the whole fill)
//   y0_i    top row (sampled at load)
//   x1_i    right column (held stable)
//   y1_i    bottom row (held stable)
//   addr_o  linear address of the current pixel
//   last_o  current pixel is the bottom-right corner
// -----------------------------------------------------------------------------
module osd_addr_gen
  import osd_pkg::*;
#(
  parameter int WIDTH  = OSD_WIDTH,
  parameter int ADDR_W = OSD_ADDR_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   step_i,
  input  logic [ADDR_W-1:0]      base_i,
  input  logic [OSD_COORD_W-1:0] x0_i,
  input  logic [OSD_COORD_W-1:0] y0_i,
  input  logic [OSD_COORD_W-1:0] x1_i,
  input  logic [OSD_COORD_W-1:0] y1_i,
  output logic [ADDR_W-1:0]      addr_o,
  output logic                   last_o
);

  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH);

  logic [OSD_COORD_W-1:0] col_q, col_d;
  logic [OSD_COORD_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      row_base_q, row_base_d;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    if (load_i) begin
      col_d      = x0_i;
      row_d      = y0_i;
      addr_d     = base_i;
      row_base_d = base_i;
    end else if (step_i) begin
      if (col_q == x1_i) begin
        // Wrap to the left edge of the next row.
        col_d      = x0_i;
        row_d      = row_q + 1'b1;
        addr_d     = row_base_q + ROW_STRIDE;
        row_base_d = row_base_q + ROW_STRIDE;
      end else begin
        col_d  = col_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (col_q == x1_i) && (row_q == y1_i);

endmodule

// File: rtl/osd_rect_writer.sv
// -----------------------------------------------------------------------------
// osd_rect_writer
// Accepts rectangle-fill commands and streams one registered pixel write per
// clock to the OSD bitmap RAM, in raster order.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a command (ready drops for one cycle after oERR)
// CHECK | validate latched command, compute first address
// FILL  | one write per clock until the bottom-right pixel
// DONE  | pulse oDONE, no write
//
// Ports:
//   iCLK        clock (also the RAM write clock)
//   iRST        synchronous active-high reset
//   iCMD_VALID  command valid
//   oCMD_READY  command can be accepted
//   iCMD_X0/Y0  top-left corner, inclusive
//   iCMD_X1/Y1  bottom-right corner, inclusive
//   iCMD_COLOR  pixel value to write
//   oWR_ADDR    RAM write address (y*WIDTH + x)
//   oWR_DATA    RAM write data
//   oWR_EN      RAM write enable
//   oBUSY       command in progress
//   oDONE       one-cycle pulse after the last write
//   oERR        one-cycle pulse on a rejected command
// -----------------------------------------------------------------------------
module osd_rect_writer
  import osd_pkg::*;
#(
  parameter int WIDTH  = OSD_WIDTH,
  parameter int HEIGHT = OSD_HEIGHT,
  parameter int ADDR_W = OSD_ADDR_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic [9:0]        iCMD_X0,
  input  logic [9:0]        iCMD_Y0,
  input  logic [9:0]        iCMD_X1,
  input  logic [9:0]        iCMD_Y1,
  input  logic              iCMD_COLOR,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic              oWR_DATA,
  output logic              oWR_EN,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CHECK = CHECK;
  localparam logic [1:0] ST_FILL  = FILL;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]        state_q, state_d;
  osd_cmd_t          cmd_q, cmd_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_data_q, wr_data_d;

  logic              gen_load;
  logic              gen_step;
  logic              gen_last;
  logic [ADDR_W-1:0] gen_addr;
  logic [ADDR_W-1:0] first_base;

  // Start address of the rectangle; registered into the walker on load.
  assign first_base = ADDR_W'(cmd_q.y0) * ADDR_W'(WIDTH) + ADDR_W'(cmd_q.x0);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = 1'b0;
    gen_load  = 1'b0;
    gen_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iCMD_VALID && ready_q) begin
          cmd_d   = '{x0: iCMD_X0, y0: iCMD_Y0, x1: iCMD_X1, y1: iCMD_Y1,
                      color: iCMD_COLOR};
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!cmd_in_bounds(cmd_q, WIDTH, HEIGHT)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gen_load  = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = cmd_q.color;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (gen_last) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          gen_step  = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = cmd_q.color;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Ready is held off during the oERR cycle so it reappears one cycle later.
    ready_d = (state_d == ST_IDLE) && !err_d;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  osd_addr_gen #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .load_i (gen_load),
    .step_i (gen_step),
    .base_i (first_base),
    .x0_i   (cmd_q.x0),
    .y0_i   (cmd_q.y0),
    .x1_i   (cmd_q.x1),
    .y1_i   (cmd_q.y1),
    .addr_o (gen_addr),
    .last_o (gen_last)
  );

  assign oCMD_READY = ready_q;
  assign oWR_ADDR   = gen_addr;
  assign oWR_DATA   = wr_data_q;
  assign oWR_EN     = wr_en_q;
  assign oBUSY      = (state_q != ST_IDLE);
  assign oDONE      = done_q;
  assign oERR       = err_q;

endmodule

// File: tb/tb_osd_rect_writer.sv
// -----------------------------------------------------------------------------
// tb_osd_rect_writer
// Directed bench for osd_rect_writer. Outputs are sampled on the falling edge.
// Status vector order: {ready, busy, wr_en, wr_data, done, err}.
// -----------------------------------------------------------------------------
module tb_osd_rect_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [9:0]  x0, y0, x1, y1;
  logic        color;
  logic [18:0] waddr;
  logic        wdata, wen, busy, done, err;
  logic [5:0]  st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign st = {ready, busy, wen, wdata, done, err};

  osd_rect_writer dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iCMD_VALID (valid),
    .oCMD_READY (ready),
    .iCMD_X0    (x0),
    .iCMD_Y0    (y0),
    .iCMD_X1    (x1),
    .iCMD_Y1    (y1),
    .iCMD_COLOR (color),
    .oWR_ADDR   (waddr),
    .oWR_DATA   (wdata),
    .oWR_EN     (wen),
    .oBUSY      (busy),
    .oDONE      (done),
    .oERR       (err)
  );

  // Presents a command and returns at the falling edge of cycle T+1.
  task automatic issue(input logic [9:0] a, input logic [9:0] b,
                       input logic [9:0] c, input logic [9:0] d,
                       input logic col, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL issue_ready got 0 want 1 (timeout)");
    end
    x0 = a; y0 = b; x1 = c; y1 = d; color = col; valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (st !== 6'b100000) begin
      errors++; $display("FAIL reset_status got %b want %b", st, 6'b100000);
    end
    checks++;
    if (waddr !== 19'd0) begin
      errors++; $display("FAIL reset_addr got %0d want 0", waddr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    issue(10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
    checks++;
    if (st !== 6'b010000) begin
      errors++; $display("FAIL single_t1 got %b want %b", st, 6'b010000);
    end
    @(negedge clk);
    checks++;
    if (st !== 6'b011100 || waddr !== 19'd0) begin
      errors++; $display("FAIL single_t2 got %b/%0d want %b/0", st, waddr, 6'b011100);
    end
    @(negedge clk);
    checks++;
    if (st !== 6'b010010) begin
      errors++; $display("FAIL single_t3 got %b want %b", st, 6'b010010);
    end
    @(negedge clk);
    checks++;
    if (st !== 6'b100000) begin
      errors++; $display("FAIL single_t4 got %b want %b", st, 6'b100000);
    end
  endtask

  task automatic test_rect();
    int exp_addr[6] = '{1050, 1051, 1052, 1570, 1571, 1572};
    issue(10'd10, 10'd2, 10'd12, 10'd3, 1'b0, 1'b0);
    checks++;
    if (st !== 6'b010000) begin
      errors++; $display("FAIL rect_check got %b want %b", st, 6'b010000);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (st !== 6'b011000 || waddr !== 19'(exp_addr[i])) begin
        errors++;
        $display("FAIL rect_write%0d got %b/%0d want %b/%0d", i, st, waddr, 6'b011000, exp_addr[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (st !== 6'b010010) begin
      errors++; $display("FAIL rect_done got %b want %b", st, 6'b010010);
    end
    @(negedge clk);
    checks++;
    if (st !== 6'b100000) begin
      errors++; $display("FAIL rect_idle got %b want %b", st, 6'b100000);
    end
  endtask

  task automatic test_invalid();
    logic [9:0] cx0[3] = '{10'd0, 10'd5, 10'd0};
    logic [9:0] cy0[3] = '{10'd0, 10'd0, 10'd0};
    logic [9:0] cx1[3] = '{10'd520, 10'd4, 10'd0};
    logic [9:0] cy1[3] = '{10'd0, 10'd0, 10'd400};
    for (int k = 0; k < 3; k++) begin
      issue(cx0[k], cy0[k], cx1[k], cy1[k], 1'b1, 1'b0);
      checks++;
      if (st !== 6'b010000) begin
        errors++; $display("FAIL invalid%0d_t1 got %b want %b", k, st, 6'b010000);
      end
      @(negedge clk);
      checks++;
      if (st !== 6'b000001) begin
        errors++; $display("FAIL invalid%0d_err got %b want %b", k, st, 6'b000001);
      end
      @(negedge clk);
      checks++;
      if (st !== 6'b100000) begin
        errors++; $display("FAIL invalid%0d_ready got %b want %b", k, st, 6'b100000);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int exp_addr[4] = '{523, 524, 1043, 1044};
    issue(10'd3, 10'd1, 10'd4, 10'd2, 1'b1, 1'b1);
    checks++;
    if (st !== 6'b010000) begin
      errors++; $display("FAIL ignore_check got %b want %b", st, 6'b010000);
    end
    for (int i = 0; i < 4; i++) begin
      x0 = 10'($urandom_range(0, 519)); x1 = 10'($urandom_range(0, 519));
      y0 = 10'($urandom_range(0, 399)); y1 = 10'($urandom_range(0, 399));
      color = 1'b0;
      @(negedge clk);
      checks++;
      if (st !== 6'b011100 || waddr !== 19'(exp_addr[i])) begin
        errors++;
        $display("FAIL ignore_write%0d got %b/%0d want %b/%0d", i, st, waddr, 6'b011100, exp_addr[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (st !== 6'b010010) begin
      errors++; $display("FAIL ignore_done got %b want %b", st, 6'b010010);
    end
    valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (st !== 6'b100000) begin
        errors++; $display("FAIL ignore_idle got %b want %b", st, 6'b100000);
      end
    end
  endtask

  // Bottom quarter at full width: covers the last address in the bitmap.
  task automatic test_full_rows();
    int nw = 0, first = -1, last = -1, seq_err = 0, gap = 0, busy_err = 0;
    bit seen_done = 1'b0;
    logic [18:0] expa = 19'd156000;
    issue(10'd0, 10'd300, 10'd519, 10'd399, 1'b1, 1'b0);
    if (!busy) busy_err++;
    for (int k = 0; k < 60000 && !seen_done; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      else begin
        if (!busy) busy_err++;
        if (wen) begin
          if (nw == 0) first = int'(waddr);
          if (waddr !== expa || wdata !== 1'b1) seq_err++;
          expa = expa + 19'd1;
          last = int'(waddr);
          nw++;
        end else if (nw > 0) gap++;
      end
    end
    checks++;
    if (!seen_done) begin
      errors++; $display("FAIL full_done got 0 want 1 (timeout)");
    end
    checks++;
    if (nw != 52000) begin
      errors++; $display("FAIL full_count got %0d want 52000", nw);
    end
    checks++;
    if (first != 156000 || last != 207999) begin
      errors++; $display("FAIL full_ends got %0d..%0d want 156000..207999", first, last);
    end
    checks++;
    if (seq_err != 0 || gap != 0 || busy_err != 0) begin
      errors++;
      $display("FAIL full_stream got seq=%0d gap=%0d busy=%0d want 0/0/0", seq_err, gap, busy_err);
    end
    @(negedge clk);
    checks++;
    if (st !== 6'b100000) begin
      errors++; $display("FAIL full_idle got %b want %b", st, 6'b100000);
    end
  endtask

  task automatic test_reset_mid_fill();
    int stray = 0;
    issue(10'd0, 10'd0, 10'd519, 10'd399, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    checks++;
    if (st !== 6'b011100 || waddr !== 19'd299) begin
      errors++; $display("FAIL midfill_write got %b/%0d want %b/299", st, waddr, 6'b011100);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (st !== 6'b100000) begin
      errors++; $display("FAIL midfill_abort got %b want %b", st, 6'b100000);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wen || done || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL midfill_quiet got %0d want 0", stray);
    end
    issue(10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (st !== 6'b011100 || waddr !== 19'd0) begin
      errors++; $display("FAIL after_rst_write got %b/%0d want %b/0", st, waddr, 6'b011100);
    end
    @(negedge clk);
    checks++;
    if (st !== 6'b010010) begin
      errors++; $display("FAIL after_rst_done got %b want %b", st, 6'b010010);
    end
    @(negedge clk);
    checks++;
    if (st !== 6'b100000) begin
      errors++; $display("FAIL after_rst_idle got %b want %b", st, 6'b100000);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rect();
    test_invalid();
    test_ignore_busy();
    test_full_rows();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_rect_writer.md
Name: osd_rect_writer

Overview:
- Command-driven writer for the 1-bit OSD bitmap; sits directly upstream of the OSD RAM write port.
- Accepts rectangle-fill commands over a valid/ready handshake.
- Emits one pixel write per clock (address, data, enable) in raster order.
- Uses: screen clear, text-box backgrounds, cursor blocks. The host never has to generate per-pixel writes itself.

Parameters:
- WIDTH, 520, bitmap width in pixels (OSD window 640-120).
- HEIGHT, 400, bitmap height in pixels (OSD window 480-80).
- ADDR_W, 19, write address width; linear address = y*WIDTH + x.

Ports:
- iCLK  input  1  single clock; also drives the RAM write clock.
- iRST  input  1  synchronous, active-high reset.
- iCMD_VALID  input  1  command valid.
- oCMD_READY  output  1  block can accept a command.
- iCMD_X0  input  10  left column, inclusive.
- iCMD_Y0  input  10  top row, inclusive.
- iCMD_X1  input  10  right column, inclusive.
- iCMD_Y1  input  10  bottom row, inclusive.
- iCMD_COLOR  input  1  pixel value written (1 = ON colour, 0 = OFF colour).
- oWR_ADDR  output  ADDR_W  RAM write address.
- oWR_DATA  output  1  RAM write data.
- oWR_EN  output  1  RAM write enable.
- oBUSY  output  1  high while a command is being processed.
- oDONE  output  1  one-cycle pulse after the last write of a command.
- oERR  output  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (iRST sampled high at a clock edge):
  - state = IDLE; oCMD_READY = 1.
  - oWR_EN, oWR_DATA, oBUSY, oDONE, oERR = 0; oWR_ADDR = 0.
  - Reset during FILL aborts immediately. No further writes occur and no oDONE is issued.
- States: IDLE, CHECK, FILL, DONE.
- IDLE:
  - oCMD_READY = 1.
  - Accept when iCMD_VALID & oCMD_READY at edge T; latch all fields.
  - Next state CHECK at T+1; oCMD_READY = 0 from T+1.
- CHECK (one cycle):
  - Reject if X0 > X1, Y0 > Y1, X1 >= WIDTH, or Y1 >= HEIGHT.
  - Reject path: oERR = 1 for exactly the following cycle, state returns to IDLE with no writes, oCMD_READY = 1 one cycle after the oERR pulse.
  - Otherwise compute base = Y0*WIDTH + X0 (registered multiply), load col = X0, row = Y0, and go to FILL.
- FILL:
  - First write asserted at T+2.
  - Each cycle: oWR_EN = 1, oWR_DATA = latched colour, oWR_ADDR = current address. Outputs are registered.
  - Raster order: col increments to X1, then col = X0, row += 1.
  - Address arithmetic is incremental, with no multiplier in FILL:
    - within a row: addr += 1.
    - row wrap: addr = row_base + WIDTH; row_base updated.
  - Writes are back-to-back, with no gaps.
  - Total writes = (X1-X0+1)*(Y1-Y0+1).
  - After the write at (X1, Y1), go to DONE.
- DONE (one cycle):
  - oWR_EN = 0, oDONE = 1.
  - Next cycle: IDLE with oCMD_READY = 1.
- Command handling:
  - iCMD_VALID asserted while busy is ignored and not queued.
  - Command fields are sampled only at acceptance; later input changes have no effect.
- Single-pixel command (X0 = X1, Y0 = Y1): exactly one write, oDONE on the following cycle.
- Max command (full bitmap): 208000 writes; last address 207999 fits in ADDR_W.
- oBUSY = 1 in CHECK, FILL and DONE.
- oWR_EN is 0 in every state except FILL.

Decomposition:
- Shared package osd_pkg:
  - constants OSD_WIDTH = 520, OSD_HEIGHT = 400, OSD_ADDR_W = 19.
  - state enum {IDLE, CHECK, FILL, DONE}.
  - command struct {x0, y0, x1, y1, color}.
- One natural sub-module, osd_addr_gen: holds the col/row counters and the address/row_base accumulator, with load, step and last outputs. The top holds the FSM, the handshake and the bounds check.

Test Plan:
- Command (0,0)-(0,0), colour 1:
  - accepted at T; single write addr 0, data 1 at T+2.
  - oDONE at T+3; oCMD_READY = 1 at T+4.
- Command (10,2)-(12,3), colour 0:
  - writes at addrs 1050, 1051, 1052, 1570, 1571, 1572 on consecutive cycles, data 0.
  - oDONE the cycle after 1572.
- Full clear (0,0)-(519,399):
  - exactly 208000 write cycles, first addr 0, last addr 207999, no enable gaps.
  - oBUSY high throughout.
- Invalid command X1 = 520, then a separate command X0 = 5, X1 = 4:
  - each gives an oERR pulse, zero writes, and oCMD_READY restored after.
- iCMD_VALID held high with changing coordinates during FILL:
  - ignored; write sequence matches the originally latched command only.
- iRST asserted mid-FILL of (0,0)-(519,399):
  - next cycle oWR_EN = 0, oBUSY = 0, oCMD_READY = 1, no oDONE.
  - a following (0,0)-(0,0) command executes normally.
